// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin owner of a shared 2:1 mux with hold limit.
//
// Ports:
//   clk, rst       rising-edge clock, async active-high reset
//   req0, req1     requests; a requester holds req high while it needs the mux
//   in0, in1       requester data (WIDTH bits)
//   gnt0, gnt1     grants, decoded from the state register
//   s              mux select (0 = in0, 1 = in1), registered
//   out, valid     registered mux output and its qualifier (lags grant by 1)
module mux2_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             s,
    output logic [WIDTH-1:0] out,
    output logic             valid
);

    localparam int HW = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_s;
    logic             r_last;
    logic [HW-1:0]    r_hold;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;

    logic             w_hold_inc;
    logic             w_hold_max;
    logic             w_enter0;
    logic             w_enter1;

    assign w_hold_max = (r_hold == HW'(MAX_HOLD - 1));
    assign w_enter0   = (w_next == G0) && (r_state != G0);
    assign w_enter1   = (w_next == G1) && (r_state != G1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; hold counting only runs while the other side waits
    always_comb begin
        w_next     = r_state;
        w_hold_inc = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req0 && req1) begin
                    w_next = r_last ? G0 : G1;
                end else if (req0) begin
                    w_next = G0;
                end else if (req1) begin
                    w_next = G1;
                end
            end
            G0: begin
                if (!req0) begin
                    w_next = req1 ? G1 : IDLE;
                end else if (req1) begin
                    if (w_hold_max) w_next = G1;
                    else            w_hold_inc = 1'b1;
                end
            end
            G1: begin
                if (!req1) begin
                    w_next = req0 ? G0 : IDLE;
                end else if (req0) begin
                    if (w_hold_max) w_next = G0;
                    else            w_hold_inc = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Select, fairness memory, hold counter and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s     <= 1'b0;
            r_last  <= 1'b1;
            r_hold  <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (r_state != IDLE);
            if (r_state != IDLE) begin
                r_out <= r_s ? in1 : in0;
            end
            if (w_enter0) begin
                r_s    <= 1'b0;
                r_last <= 1'b0;
                r_hold <= '0;
            end else if (w_enter1) begin
                r_s    <= 1'b1;
                r_last <= 1'b1;
                r_hold <= '0;
            end else if (w_hold_inc) begin
                r_hold <= r_hold + 1'b1;
            end else begin
                r_hold <= '0;
            end
        end
    end

    // Output decode
    always_comb begin
        gnt0  = (r_state == G0);
        gnt1  = (r_state == G1);
        s     = r_s;
        out   = r_out;
        valid = r_valid;
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed vectors for the 2:1 mux round-robin arbiter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [0:0] in0, in1;
    logic       gnt0, gnt1, s, valid;
    logic [0:0] out;

    int vectors    = 0;
    int miscompares = 0;

    mux2_rr_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .in0   (in0),
        .in1   (in1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .s     (s),
        .out   (out),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_gnt0", 32'(gnt0), 0);
        check("rst_gnt1", 32'(gnt1), 0);
        check("rst_s", 32'(s), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_out", 32'(out), 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; in0 = 1'b1; in1 = 1'b0;

        // 1. Reset with both requesting, then req0 wins the first tie
        repeat (3) begin
            tick();
            check("t1_rst_gnt", 32'({gnt0, gnt1}), 0);
            check("t1_rst_sov", 32'({s, out, valid}), 0);
        end
        rst = 1'b0;
        tick();
        check("t1_gnt0", 32'(gnt0), 1);
        check("t1_gnt1", 32'(gnt1), 0);
        check("t1_s", 32'(s), 0);
        check("t1_valid0", 32'(valid), 0);
        tick();
        check("t1_valid", 32'(valid), 1);
        check("t1_out", 32'(out), 1);

        // Async reset mid-grant clears immediately
        rst = 1'b1;
        #1;
        check("arst_gnt", 32'({gnt0, gnt1}), 0);
        check("arst_valid", 32'(valid), 0);
        check("arst_out", 32'(out), 0);
        tick();
        rst = 1'b0;

        // 2. Single requester on side 1 for 10 cycles
        req0 = 1'b0; req1 = 1'b1; in0 = 1'b0; in1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t2_gnt1", 32'(gnt1), 1);
            check("t2_gnt0", 32'(gnt0), 0);
            check("t2_valid", 32'(valid), (k >= 2) ? 1 : 0);
            if (k >= 2) check("t2_out", 32'(out), 1);
        end
        req1 = 1'b0;
        tick();
        check("t2_drop_gnt1", 32'(gnt1), 0);
        check("t2_drop_valid", 32'(valid), 1);
        tick();
        check("t2_idle_valid", 32'(valid), 0);
        check("t2_idle_out", 32'(out), 1);
        check("t2_idle_s", 32'(s), 1);

        // 3. Handoff G0 -> G1 with no bubble
        do_reset();
        req0 = 1'b1; req1 = 1'b0;
        tick();
        check("t3_g0", 32'(gnt0), 1);
        tick();
        req1 = 1'b1;
        tick();
        check("t3_g0_w1", 32'({gnt0, gnt1}), 2);
        tick();
        check("t3_g0_w2", 32'({gnt0, gnt1}), 2);
        req0 = 1'b0;
        tick();
        check("t3_hand", 32'({gnt0, gnt1}), 1);
        check("t3_s", 32'(s), 1);

        // 4. Preemption: both requesting, 4-cycle alternation
        do_reset();
        req0 = 1'b1; req1 = 1'b1; in0 = 1'b0; in1 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("t4_gnt1", 32'(gnt1), ((k - 1) / 4) % 2);
            check("t4_gnt0", 32'(gnt0), 1 - ((k - 1) / 4) % 2);
            check("t4_s", 32'(s), ((k - 1) / 4) % 2);
            if (k == 1) begin
                check("t4_valid0", 32'(valid), 0);
            end else begin
                check("t4_valid", 32'(valid), 1);
                check("t4_out", 32'(out), ((k - 2) / 4) % 2);
            end
        end

        // 5. Tie after side 0 last served -> side 1 first
        do_reset();
        req0 = 1'b1; req1 = 1'b0;
        tick();
        check("t5_g0", 32'(gnt0), 1);
        req0 = 1'b0;
        tick();
        check("t5_idle", 32'({gnt0, gnt1}), 0);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("t5_tie", 32'({gnt0, gnt1}), 1);

        // 6. Mux sweep: 4 data combos with s=0, then with s=1
        do_reset();
        req0 = 1'b1; req1 = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            in0 = 1'(c >> 1);
            in1 = 1'(c);
            tick();
            check("t6_s0_out", 32'(out), (c >> 1) & 1);
        end
        req0 = 1'b0; req1 = 1'b1;
        tick();
        check("t6_s1", 32'(s), 1);
        for (int c = 0; c < 4; c++) begin
            in0 = 1'(c >> 1);
            in1 = 1'(c);
            tick();
            check("t6_s1_out", 32'(out), c & 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
